// File: rtl/packet_link_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : packet_link_ctrl_if
// Brief    : Bundles the payload stream, UART TX/RX, CRC-8 and status signals
//            of packet_link_ctrl. master = controller side, slave = glue side.
// Revision : 1.0 - initial release
// ============================================================================
interface packet_link_ctrl_if #(
    parameter int LEN_W = 8
);
    logic             start_btn;
    logic [LEN_W-1:0] tx_len;
    logic [7:0]       pl_data;
    logic             pl_valid;
    logic             pl_ready;
    logic             tx_busy;
    logic             tx_start;
    logic [7:0]       tx_data;
    logic             crc_init_tx;
    logic             crc_data_valid_tx;
    logic [7:0]       crc_data_in_tx;
    logic [7:0]       crc_out_tx;
    logic             tx_done;
    logic             tx_err;
    logic             rx_done;
    logic [7:0]       rx_data;
    logic             crc_init_rx;
    logic             crc_data_valid_rx;
    logic [7:0]       crc_data_in_rx;
    logic [7:0]       crc_out_rx;
    logic             rx_out_valid;
    logic [7:0]       rx_out_data;
    logic             frame_ok;
    logic             frame_err;
    logic [1:0]       display_status;

    modport master (
        input  start_btn, tx_len, pl_data, pl_valid, tx_busy, crc_out_tx,
               rx_done, rx_data, crc_out_rx,
        output pl_ready, tx_start, tx_data, crc_init_tx, crc_data_valid_tx,
               crc_data_in_tx, tx_done, tx_err, crc_init_rx, crc_data_valid_rx,
               crc_data_in_rx, rx_out_valid, rx_out_data, frame_ok, frame_err,
               display_status
    );

    modport slave (
        output start_btn, tx_len, pl_data, pl_valid, tx_busy, crc_out_tx,
               rx_done, rx_data, crc_out_rx,
        input  pl_ready, tx_start, tx_data, crc_init_tx, crc_data_valid_tx,
               crc_data_in_tx, tx_done, tx_err, crc_init_rx, crc_data_valid_rx,
               crc_data_in_rx, rx_out_valid, rx_out_data, frame_ok, frame_err,
               display_status
    );
endinterface
`default_nettype wire

// File: rtl/packet_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : packet_link_ctrl
// Brief    : LEN/payload/CRC-8 framing controller between a payload stream and
//            byte UART TX/RX. Optional RX inter-byte timeout: LINK_RX_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module packet_link_ctrl #(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 8
`ifdef LINK_RX_TIMEOUT_EN
   ,parameter int TIMEOUT_CYC = 50000
`endif
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    packet_link_ctrl_if.master bus
);
    localparam logic [LEN_W-1:0] c_max_len      = LEN_W'(MAX_LEN);
    localparam logic [7:0]       c_max_len_byte = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0, TX_HDR = 3'd1, TX_HDR_W = 3'd2, TX_PL   = 3'd3,
        TX_PL_W  = 3'd4, TX_CRC = 3'd5, TX_CRC_W = 3'd6, TX_DONE = 3'd7
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0, RX_PL = 2'd1, RX_CRC = 2'd2, RX_CHECK = 2'd3
    } rx_state_t;

    tx_state_t        r_tx_state;
    logic [LEN_W-1:0] r_tx_len;
    logic [LEN_W-1:0] r_tx_cnt;
    logic             r_tx_guard;
    rx_state_t        r_rx_state;
    logic [LEN_W-1:0] r_rx_len;
    logic [LEN_W-1:0] r_rx_cnt;
    logic [1:0]       r_status;

    logic             w_tx_len_ok;
    logic             w_tx_wait_done;
    logic             w_rx_len_ok;
    logic [LEN_W-1:0] w_rx_cnt_nxt;
    logic             w_rx_tmo;

    assign w_tx_len_ok    = (bus.tx_len != '0) && (bus.tx_len <= c_max_len);
    // The UART may raise busy a cycle late, so the cycle after tx_start is blind.
    assign w_tx_wait_done = !r_tx_guard && !bus.tx_busy;
    assign w_rx_len_ok    = (bus.rx_data != 8'd0) && (bus.rx_data <= c_max_len_byte);
    assign w_rx_cnt_nxt   = r_rx_cnt + LEN_W'(1);
    assign bus.display_status = r_status;

`ifdef LINK_RX_TIMEOUT_EN
    localparam int                 c_tmo_w    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYC - 1);
    logic [c_tmo_w-1:0] r_tmo;

    assign w_rx_tmo = ((r_rx_state == RX_PL) || (r_rx_state == RX_CRC)) &&
                      !bus.rx_done && (r_tmo == c_tmo_last);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tmo <= '0;
        end else if (((r_rx_state == RX_PL) || (r_rx_state == RX_CRC)) &&
                     !bus.rx_done && !w_rx_tmo) begin
            r_tmo <= r_tmo + c_tmo_w'(1);
        end else begin
            r_tmo <= '0;
        end
    end
`else
    assign w_rx_tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_state <= TX_IDLE;
            r_tx_len   <= '0;
            r_tx_cnt   <= '0;
            r_tx_guard <= 1'b0;
        end else begin
            r_tx_guard <= bus.tx_start;
            case (r_tx_state)
                TX_IDLE: if (bus.start_btn && w_tx_len_ok) begin
                    r_tx_len   <= bus.tx_len;
                    r_tx_cnt   <= '0;
                    r_tx_state <= TX_HDR;
                end
                TX_HDR:   r_tx_state <= TX_HDR_W;
                TX_HDR_W: if (w_tx_wait_done) r_tx_state <= TX_PL;
                TX_PL: if (bus.pl_valid) begin
                    r_tx_cnt   <= r_tx_cnt + LEN_W'(1);
                    r_tx_state <= TX_PL_W;
                end
                TX_PL_W: if (w_tx_wait_done)
                    r_tx_state <= (r_tx_cnt < r_tx_len) ? TX_PL : TX_CRC;
                TX_CRC:   r_tx_state <= TX_CRC_W;
                TX_CRC_W: if (w_tx_wait_done) r_tx_state <= TX_DONE;
                default:  r_tx_state <= TX_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.pl_ready          = 1'b0;
        bus.tx_start          = 1'b0;
        bus.tx_data           = 8'd0;
        bus.crc_init_tx       = 1'b0;
        bus.crc_data_valid_tx = 1'b0;
        bus.crc_data_in_tx    = 8'd0;
        bus.tx_done           = 1'b0;
        bus.tx_err            = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                bus.crc_init_tx = bus.start_btn && w_tx_len_ok;
                bus.tx_err      = bus.start_btn && !w_tx_len_ok;
            end
            TX_HDR: begin
                bus.tx_start          = 1'b1;
                bus.tx_data           = 8'(r_tx_len);
                bus.crc_data_valid_tx = 1'b1;
                bus.crc_data_in_tx    = 8'(r_tx_len);
            end
            TX_PL: begin
                bus.pl_ready = 1'b1;
                if (bus.pl_valid) begin
                    bus.tx_start          = 1'b1;
                    bus.tx_data           = bus.pl_data;
                    bus.crc_data_valid_tx = 1'b1;
                    bus.crc_data_in_tx    = bus.pl_data;
                end
            end
            TX_CRC: begin
                bus.tx_start = 1'b1;
                bus.tx_data  = bus.crc_out_tx;
            end
            TX_DONE: bus.tx_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_state <= RX_IDLE;
            r_rx_len   <= '0;
            r_rx_cnt   <= '0;
            r_status   <= 2'b11;
        end else begin
            case (r_rx_state)
                RX_IDLE: if (bus.rx_done) begin
                    if (w_rx_len_ok) begin
                        r_rx_len   <= LEN_W'(bus.rx_data);
                        r_rx_cnt   <= '0;
                        r_status   <= 2'b11;
                        r_rx_state <= RX_PL;
                    end else begin
                        r_status <= 2'b00;
                    end
                end
                RX_PL: begin
                    if (w_rx_tmo) begin
                        r_status   <= 2'b10;
                        r_rx_state <= RX_IDLE;
                    end else if (bus.rx_done) begin
                        r_rx_cnt <= w_rx_cnt_nxt;
                        if (w_rx_cnt_nxt == r_rx_len) r_rx_state <= RX_CRC;
                    end
                end
                RX_CRC: begin
                    if (w_rx_tmo) begin
                        r_status   <= 2'b10;
                        r_rx_state <= RX_IDLE;
                    end else if (bus.rx_done) begin
                        r_rx_state <= RX_CHECK;
                    end
                end
                default: begin
                    r_status   <= (bus.crc_out_rx == 8'd0) ? 2'b01 : 2'b00;
                    r_rx_state <= RX_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus.crc_init_rx       = 1'b0;
        bus.crc_data_valid_rx = 1'b0;
        bus.crc_data_in_rx    = 8'd0;
        bus.rx_out_valid      = 1'b0;
        bus.rx_out_data       = 8'd0;
        bus.frame_ok          = 1'b0;
        bus.frame_err         = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                bus.crc_init_rx = 1'b1;
                if (bus.rx_done) begin
                    bus.crc_data_valid_rx = w_rx_len_ok;
                    bus.crc_data_in_rx    = bus.rx_data;
                    bus.frame_err         = !w_rx_len_ok;
                end
            end
            RX_PL: begin
                bus.frame_err = w_rx_tmo;
                if (bus.rx_done) begin
                    bus.crc_data_valid_rx = 1'b1;
                    bus.crc_data_in_rx    = bus.rx_data;
                    bus.rx_out_valid      = 1'b1;
                    bus.rx_out_data       = bus.rx_data;
                end
            end
            RX_CRC: begin
                bus.frame_err = w_rx_tmo;
                if (bus.rx_done) begin
                    bus.crc_data_valid_rx = 1'b1;
                    bus.crc_data_in_rx    = bus.rx_data;
                end
            end
            default: begin
                bus.frame_ok  = (bus.crc_out_rx == 8'd0);
                bus.frame_err = (bus.crc_out_rx != 8'd0);
            end
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_packet_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_packet_link_ctrl
// Brief    : Directed bench for packet_link_ctrl with UART loopback and CRC-8
//            (poly 0x07) models. Timeout checks need LINK_RX_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_packet_link_ctrl;
    localparam int MAX_LEN = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    packet_link_ctrl_if #(.LEN_W(8)) bus ();

    packet_link_ctrl #(
        .MAX_LEN(MAX_LEN),
        .LEN_W  (8)
`ifdef LINK_RX_TIMEOUT_EN
       ,.TIMEOUT_CYC(100)
`endif
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] x;
        x = c ^ d;
        for (int i = 0; i < 8; i++) x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
        return x;
    endfunction

    // CRC-8 units: output updates one cycle after data_valid
    logic [7:0] crc_tx = 8'd0;
    logic [7:0] crc_rx = 8'd0;
    always @(posedge clk) begin
        if (bus.crc_data_valid_tx) crc_tx <= crc8(bus.crc_init_tx ? 8'd0 : crc_tx, bus.crc_data_in_tx);
        else if (bus.crc_init_tx)  crc_tx <= 8'd0;
        if (bus.crc_data_valid_rx) crc_rx <= crc8(bus.crc_init_rx ? 8'd0 : crc_rx, bus.crc_data_in_rx);
        else if (bus.crc_init_rx)  crc_rx <= 8'd0;
    end
    assign bus.crc_out_tx = crc_tx;
    assign bus.crc_out_rx = crc_rx;

    // UART TX model: busy rises one cycle late, byte looped back to RX when done
    int         u_cnt   = 0;
    logic [7:0] u_byte  = 8'd0;
    logic       loop_en = 1'b1;
    logic       l_done  = 1'b0;
    logic [7:0] l_data  = 8'd0;
    int         l_idx   = 0;
    int         flip_at = -1;
    int         overlap = 0;
    logic       d_rx_done = 1'b0;
    logic [7:0] d_rx_data = 8'd0;
    always @(posedge clk) begin
        l_done <= 1'b0;
        if (u_cnt > 0) begin
            u_cnt <= u_cnt - 1;
            if (bus.tx_start) overlap <= overlap + 1;
            if (u_cnt == 1 && loop_en) begin
                l_done <= 1'b1;
                l_data <= u_byte ^ ((l_idx == flip_at) ? 8'h01 : 8'h00);
                l_idx  <= l_idx + 1;
            end
        end else if (bus.tx_start) begin
            u_byte <= bus.tx_data;
            u_cnt  <= 6;
        end
    end
    assign bus.tx_busy = (u_cnt >= 1) && (u_cnt <= 5);
    assign bus.rx_done = l_done | d_rx_done;
    assign bus.rx_data = l_done ? l_data : d_rx_data;

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    int n_txdone = 0, n_txerr = 0, n_fok = 0, n_ferr = 0;
    always @(negedge clk) begin
        if (bus.tx_start)     tx_q.push_back(bus.tx_data);
        if (bus.rx_out_valid) rx_q.push_back(bus.rx_out_data);
        if (bus.tx_done)      n_txdone++;
        if (bus.tx_err)       n_txerr++;
        if (bus.frame_ok)     n_fok++;
        if (bus.frame_err)    n_ferr++;
    end

    logic [7:0] pl_buf [0:255];

    task automatic send_rx(input logic [7:0] b);
        @(posedge clk); #1;
        d_rx_data = b;
        d_rx_done = 1'b1;
        @(posedge clk); #1;
        d_rx_done = 1'b0;
    endtask

    // Sends one frame of pl_buf[0..len-1] through TX loopback and checks both sides
    task automatic run_frame(input string tag, input int len, input int flip_pl,
                             input int stall_idx, input int stall_n);
        int b_tx, b_rx, b_done, b_ok, b_err, idx, cyc, viol, left;
        logic started, hs;
        logic [7:0] exp_b [0:257];
        b_tx = tx_q.size(); b_rx = rx_q.size();
        b_done = n_txdone; b_ok = n_fok; b_err = n_ferr;
        flip_at = (flip_pl >= 0) ? l_idx + 1 + flip_pl : -1;
        exp_b[0] = 8'(len);
        for (int i = 0; i < len; i++) exp_b[i+1] = pl_buf[i];
        exp_b[len+1] = 8'd0;
        for (int i = 0; i <= len; i++) exp_b[len+1] = crc8(exp_b[len+1], exp_b[i]);

        @(posedge clk); #1;
        bus.start_btn = 1'b1;
        bus.tx_len    = 8'(len);
        @(posedge clk); #1;
        bus.start_btn = 1'b0;
        idx = 0; cyc = 0; viol = 0; left = stall_n; started = 1'b0;
        while (idx < len && cyc < 3000) begin
            if (idx == stall_idx && left > 0) begin
                bus.pl_valid = 1'b0;
                #1;
                if (started && (bus.pl_ready !== 1'b1 || bus.tx_start !== 1'b0)) viol++;
                if (bus.pl_ready) begin started = 1'b1; left--; end
                hs = 1'b0;
            end else begin
                bus.pl_valid = 1'b1;
                bus.pl_data  = pl_buf[idx];
                #1;
                hs = bus.pl_ready;
            end
            @(posedge clk); #1;
            cyc++;
            if (hs) idx++;
        end
        bus.pl_valid = 1'b0;
        chk({tag, " payload accepted"}, idx, len);
        if (stall_n > 0) begin
            chk({tag, " stall ready-held/no-start violations"}, viol, 0);
            chk({tag, " stall cycles observed"}, left, 0);
        end
        cyc = 0;
        while ((n_fok + n_ferr == b_ok + b_err || n_txdone == b_done) && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, " completion within budget"}, cyc < 2000, 1);
        chk({tag, " tx_done pulses"}, n_txdone - b_done, 1);
        chk({tag, " tx byte count"}, tx_q.size() - b_tx, len + 2);
        for (int i = 0; i < len + 2; i++)
            if (b_tx + i < tx_q.size()) chk($sformatf("%s tx byte %0d", tag, i), tx_q[b_tx+i], exp_b[i]);
        chk({tag, " frame_ok pulses"}, n_fok - b_ok, (flip_pl < 0) ? 1 : 0);
        chk({tag, " frame_err pulses"}, n_ferr - b_err, (flip_pl < 0) ? 0 : 1);
        chk({tag, " display_status"}, bus.display_status, (flip_pl < 0) ? 2'b01 : 2'b00);
        chk({tag, " rx_out_valid count"}, rx_q.size() - b_rx, len);
        for (int i = 0; i < len; i++)
            if (b_rx + i < rx_q.size())
                chk($sformatf("%s rx byte %0d", tag, i), rx_q[b_rx+i],
                    pl_buf[i] ^ ((i == flip_pl) ? 8'h01 : 8'h00));
        repeat (4) @(posedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b_tx, b_ok, b_err, b_done, b_rx, cyc;
        logic [7:0] c;
        bus.start_btn = 1'b0;
        bus.tx_len    = 8'd0;
        bus.pl_data   = 8'd0;
        bus.pl_valid  = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset display_status", bus.display_status, 2'b11);
        chk("reset pl_ready", bus.pl_ready, 1'b0);
        chk("reset tx_start", bus.tx_start, 1'b0);
        chk("reset pulses", {bus.tx_done, bus.tx_err, bus.frame_ok, bus.frame_err, bus.rx_out_valid}, 5'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // T1: "OLA" loopback
        pl_buf[0] = 8'h4F; pl_buf[1] = 8'h4C; pl_buf[2] = 8'h41;
        run_frame("T1", 3, -1, -1, 0);

        // T2: bit 0 of second payload byte corrupted on the line
        run_frame("T2", 3, 1, -1, 0);

        // T3: illegal lengths, then a maximum-length frame
        b_tx = tx_q.size();
        b_done = n_txerr;
        @(posedge clk); #1;
        bus.start_btn = 1'b1; bus.tx_len = 8'd0;
        #1;
        chk("T3 tx_err len=0", bus.tx_err, 1'b1);
        chk("T3 crc_init_tx len=0", bus.crc_init_tx, 1'b0);
        @(posedge clk); #1;
        bus.tx_len = 8'(MAX_LEN + 1);
        #1;
        chk("T3 tx_err len=MAX+1", bus.tx_err, 1'b1);
        @(posedge clk); #1;
        bus.start_btn = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("T3 tx_err pulse count", n_txerr - b_done, 2);
        chk("T3 no tx_start on bad len", tx_q.size() - b_tx, 0);
        for (int i = 0; i < MAX_LEN; i++) pl_buf[i] = 8'($urandom_range(0, 255));
        run_frame("T3", MAX_LEN, -1, -1, 0);

        // T4: payload source stalls 20 cycles mid-frame
        for (int i = 0; i < 5; i++) pl_buf[i] = 8'(8'hA0 + i);
        run_frame("T4", 5, -1, 2, 20);

        // T6: reset during TX payload and RX payload
        loop_en = 1'b0;
        b_rx = rx_q.size();
        send_rx(8'd4); send_rx(8'hAA); send_rx(8'hBB);
        chk("T6 rx partial payload out", rx_q.size() - b_rx, 2);
        b_tx = tx_q.size(); b_done = n_txdone; b_ok = n_fok; b_err = n_ferr;
        @(posedge clk); #1;
        bus.start_btn = 1'b1; bus.tx_len = 8'd4;
        @(posedge clk); #1;
        bus.start_btn = 1'b0; bus.pl_valid = 1'b1; bus.pl_data = 8'h5A;
        cyc = 0;
        while (tx_q.size() < b_tx + 2 && cyc < 200) begin @(posedge clk); #1; cyc++; end
        chk("T6 reached TX payload", cyc < 200, 1);
        reset_n = 1'b0;
        #1;
        chk("T6 async reset display_status", bus.display_status, 2'b11);
        chk("T6 async reset pl_ready", bus.pl_ready, 1'b0);
        chk("T6 async reset strobes", {bus.tx_start, bus.rx_out_valid, bus.crc_data_valid_tx}, 3'd0);
        bus.pl_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc = 0;
        while (u_cnt != 0 && cyc < 50) begin @(posedge clk); #1; cyc++; end
        repeat (20) @(posedge clk);
        #1;
        chk("T6 no tx_done after abandon", n_txdone - b_done, 0);
        chk("T6 no frame pulses after abandon", (n_fok - b_ok) + (n_ferr - b_err), 0);
        loop_en = 1'b1;
        pl_buf[0] = 8'h11; pl_buf[1] = 8'h22; pl_buf[2] = 8'h33; pl_buf[3] = 8'h44;
        run_frame("T6", 4, -1, -1, 0);

        // T5: silence after two of four payload bytes
        loop_en = 1'b0;
        b_rx = rx_q.size(); b_ok = n_fok; b_err = n_ferr;
        send_rx(8'd4); send_rx(8'h11); send_rx(8'h22);
`ifdef LINK_RX_TIMEOUT_EN
        cyc = 1;
        while (!bus.frame_err && cyc < 300) begin @(posedge clk); #1; cyc++; end
        chk("T5 timeout cycle after last byte", cyc, 100);
        @(posedge clk); #1;
        chk("T5 display_status timeout", bus.display_status, 2'b10);
        chk("T5 frame_err pulses", n_ferr - b_err, 1);
        chk("T5 partial rx_out count", rx_q.size() - b_rx, 2);
`else
        repeat (300) @(posedge clk);
        #1;
        chk("T5 no timeout frame_err", n_ferr - b_err, 0);
        chk("T5 status still busy", bus.display_status, 2'b11);
        send_rx(8'h33); send_rx(8'h44);
        c = 8'd0;
        c = crc8(c, 8'd4); c = crc8(c, 8'h11); c = crc8(c, 8'h22);
        c = crc8(c, 8'h33); c = crc8(c, 8'h44);
        send_rx(c);
        repeat (3) @(posedge clk);
        #1;
        chk("T5 late frame_ok", n_fok - b_ok, 1);
        chk("T5 late status ok", bus.display_status, 2'b01);
        chk("T5 rx_out count", rx_q.size() - b_rx, 4);
`endif
        // RX length byte of zero is rejected at once
        b_err = n_ferr;
        send_rx(8'd0);
        #1;
        chk("RX len=0 frame_err", n_ferr - b_err, 1);
        chk("RX len=0 status", bus.display_status, 2'b00);
        chk("UART overlapped tx_start", overlap, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
